// File: rtl/fft_sample_deinterleaver_pkg.sv
// Shared types and helpers for the FFT sample deinterleaver: bank states,
// default geometry and the index bit-reversal used for reordered issue.
package fft_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_N      = 8;

  function automatic int unsigned bitrev(input int unsigned k, input int unsigned w);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < w; i++) begin
      r = (r << 1) | ((k >> i) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_bank.sv
// One ping-pong frame bank: N sample registers, fill/drain state machine and
// a combinational (even, odd) pair read port.
//
// state    | meaning
// EMPTY    | no samples held, ready for a new frame
// FILLING  | some samples of a frame written
// FULL     | all N samples held, read side not yet on this bank
// DRAINING | read side is issuing pairs from this bank
module fft_pingpong_bank
  import fft_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int N      = DEFAULT_N,
  parameter int PW     = $clog2(N/2),
  parameter int AW     = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              rd_sel,
  input  logic              rd_done,
  input  logic [PW-1:0]     rd_pair,
  output logic              avail_next,
  output logic [DATA_W-1:0] rd_even,
  output logic [DATA_W-1:0] rd_odd
);

  bank_state_e       state_q, state_d;
  logic [DATA_W-1:0] mem_q [N];
  logic [DATA_W-1:0] mem_d [N];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:    if (wr_en) state_d = FILLING;
      FILLING:  if (wr_en && wr_last) state_d = FULL;
      FULL: begin
        if (rd_done)     state_d = EMPTY;
        else if (rd_sel) state_d = DRAINING;
      end
      DRAINING: if (rd_done) state_d = EMPTY;
      default:  state_d = EMPTY;
    endcase
  end

  // Next-state view lets the read side load pair 0 in the same cycle the frame completes
  assign avail_next = (state_d == FULL) || (state_d == DRAINING);
  assign rd_even    = mem_q[{rd_pair, 1'b0}];
  assign rd_odd     = mem_q[{rd_pair, 1'b1}];

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fft_sample_deinterleaver.sv
// Collects serial samples into N-sample frames across two ping-pong banks and
// issues (even, odd) pairs; FFT_DEINT_BITREV_EN selects bit-reversed pair order.
module fft_sample_deinterleaver
  import fft_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int N      = DEFAULT_N
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        even,
  output logic [DATA_W-1:0]        odd,
  output logic [$clog2(N/2)-1:0]   out_idx,
  output logic                     out_last
);

  localparam int PW = $clog2(N/2);
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] WR_MAX = AW'(N-1);
  localparam logic [PW-1:0] RD_MAX = PW'(N/2-1);

  logic [AW-1:0]     wr_cnt_q, wr_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic [PW-1:0]     rd_cnt_q, rd_cnt_d;
  logic              rd_bank_q, rd_bank_d;
  logic              rdy_q, rdy_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] even_q, even_d, odd_q, odd_d;
  logic [PW-1:0]     idx_q, idx_d;
  logic              last_q, last_d;

  logic              wr_fire, wr_last, hs, rd_wrap, load;
  logic [PW-1:0]     pidx;
  logic [1:0]        avail;
  logic [DATA_W-1:0] bank_even [2];
  logic [DATA_W-1:0] bank_odd  [2];

  assign in_ready = rdy_q && !rst;
  assign wr_fire  = in_valid && in_ready;
  assign wr_last  = (wr_cnt_q == WR_MAX);
  assign hs       = out_valid_q && out_ready;
  assign rd_wrap  = (rd_cnt_q == RD_MAX);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic ID = 1'(b);
    fft_pingpong_bank #(.DATA_W(DATA_W), .N(N), .PW(PW), .AW(AW)) u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_fire && (wr_bank_q == ID)),
      .wr_addr    (wr_cnt_q),
      .wr_data    (in_data),
      .wr_last    (wr_last),
      .rd_sel     (rd_bank_q == ID),
      .rd_done    (hs && rd_wrap && (rd_bank_q == ID)),
      .rd_pair    (pidx),
      .avail_next (avail[b]),
      .rd_even    (bank_even[b]),
      .rd_odd     (bank_odd[b])
    );
  end

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (wr_fire) begin
      if (wr_last) begin
        wr_cnt_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
    rdy_d = !avail[wr_bank_d];
  end

  always_comb begin
    rd_cnt_d    = rd_cnt_q;
    rd_bank_d   = rd_bank_q;
    load        = 1'b0;
    out_valid_d = out_valid_q;
    even_d      = even_q;
    odd_d       = odd_q;
    idx_d       = idx_q;
    last_d      = last_q;
    if (hs) begin
      if (rd_wrap) begin
        rd_cnt_d  = '0;
        rd_bank_d = ~rd_bank_q;
        load      = avail[~rd_bank_q];
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        load     = 1'b1;
      end
    end else if (!out_valid_q) begin
      load = avail[rd_bank_q];
    end
`ifdef FFT_DEINT_BITREV_EN
    pidx = PW'(bitrev(32'(rd_cnt_d), PW));
`else
    pidx = rd_cnt_d;
`endif
    if (load) begin
      out_valid_d = 1'b1;
      even_d      = bank_even[rd_bank_d];
      odd_d       = bank_odd[rd_bank_d];
      idx_d       = pidx;
      last_d      = (rd_cnt_d == RD_MAX);
    end else if (hs) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      rdy_q       <= 1'b1;
      out_valid_q <= 1'b0;
      even_q      <= '0;
      odd_q       <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rdy_q       <= rdy_d;
      out_valid_q <= out_valid_d;
      even_q      <= even_d;
      odd_q       <= odd_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign even      = even_q;
  assign odd       = odd_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;

endmodule

// File: doc/fft_sample_deinterleaver.md
# fft_sample_deinterleaver

Frame-buffering front end for the radix-2 FFT datapath: accepts a serial stream of time-domain samples, collects them into frames of N, and presents each frame as N/2 (even, odd) sample pairs to the downstream `N2_FFT` butterfly stage. Two ping-pong banks let one frame fill while the previous one drains. Valid/ready handshakes are used on both sides.

## Interface
Parameters:
- `DATA_W`, 16: sample width in bits.
- `N`, 8: samples per frame; power of two, at least 4.

Ports:
- `clk` input 1: the single clock. All logic is rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_data` carries a sample.
- `in_ready` output 1: the block can accept a sample.
- `in_data` input `DATA_W`: sample, in time order.
- `out_valid` output 1: the pair outputs are valid.
- `out_ready` input 1: downstream accepts the pair.
- `even` output `DATA_W`: sample[2k] of the current frame.
- `odd` output `DATA_W`: sample[2k+1] of the current frame.
- `out_idx` output `$clog2(N/2)`: pair index k as issued.
- `out_last` output 1: last pair of the frame.

## Operation
- Storage: two banks (A, B). Each bank holds N `DATA_W`-bit registers.
- Each bank has its own state machine with states EMPTY, FILLING, FULL and DRAINING.
  - EMPTY→FILLING: first sample accepted into the bank.
  - FILLING→FULL: N-th sample accepted.
  - FULL→DRAINING: the read side selects the bank.
  - DRAINING→EMPTY: the last pair is handshaken.
- Write pointer:
  - A write happens on `in_valid && in_ready`.
  - The sample goes to `wr_bank[wr_cnt]`.
  - `wr_cnt` wraps N-1→0; `wr_bank` toggles on the wrap.
- `in_ready` is 1 iff `wr_bank` is EMPTY or FILLING. It is registered state, not a combinational path from `out_ready`.
- Read side:
  - Reads from `rd_bank` with pair counter `rd_cnt`.
  - Pair k = {bank[2k], bank[2k+1]}.
  - On handshake (`out_valid && out_ready`), `rd_cnt` increments.
  - At `rd_cnt` = N/2-1, `rd_cnt` wraps to 0, `rd_bank` toggles and the drained bank returns to EMPTY.
- Banks are served strictly alternately, starting from A after reset: A, B, A, …
- Simultaneous events: write into one bank and drain of the other in the same cycle are both honoured. A bank freed in cycle t may be written from cycle t+1.
- Data is passed through unmodified. No arithmetic, no width change.
- Reset mid-frame: partial frames in both banks are discarded. Nothing is flushed to the output.

## Timing
- Reset values:
  - `out_valid` = 0, `even` = `odd` = 0, `out_idx` = 0, `out_last` = 0.
  - `in_ready` = 0 while `rst` is high and 1 in the first cycle after `rst` deasserts.
  - Both banks EMPTY; `wr_cnt`, `rd_cnt`, `wr_bank`, `rd_bank` = 0.
- Latency: if the N-th sample of a frame is accepted in cycle t, `out_valid` rises in cycle t+1 with pair 0 of that frame.
- All pair outputs are registered.
- While `out_valid && !out_ready`, `even`, `odd`, `out_idx` and `out_last` are held stable.
- Throughput:
  - After a pair handshake, the next pair is presented the following cycle with no bubble, including across a bank switch when the other bank is FULL.
  - Input accepts one sample per cycle. Output drains faster than it fills, so sustained streaming never stalls `in_ready` when `out_ready` = 1.
- Full condition: both banks FULL/DRAINING means `in_ready` = 0. `in_ready` returns to 1 the cycle after the last pair handshake of `rd_bank`.
- Empty condition: `rd_bank` not FULL/DRAINING means `out_valid` = 0.

## Configuration
- Macro: `FFT_DEINT_BITREV_EN`.
- Defined: pairs are issued in bit-reversed order of k, reversing `$clog2(N/2)` bits.
  - `out_idx` reports the reversed index.
  - `out_last` is asserted on the N/2-th handshake.
  - For N = 8, the issue order is k = 0, 2, 1, 3.
- Undefined: natural order k = 0…N/2-1.

## Structure
- `fft_pkg`:
  - bank-state enum (EMPTY, FILLING, FULL, DRAINING)
  - `bitrev` function
  - default `DATA_W` and `N` constants
- Sub-module `fft_pingpong_bank`: one bank's register storage, its state machine and its dual-word read port. Instantiated twice.
- The top level holds the pointers, the handshake logic and the output registers.

## Test plan
- Reset, then feed samples 1..8 back-to-back with `out_ready` = 1 → `out_valid` rises the cycle after sample 8. Pairs (1,2), (3,4), (5,6), (7,8) on consecutive cycles, with `out_idx` 0..3 and `out_last` on (7,8).
- `out_ready` held 0 while feeding 16 samples → `in_ready` drops after the 16th. Outputs stay (1,2) stable. Releasing `out_ready` drains 8 pairs with no bubble between frames, and `in_ready` returns 1 the cycle after pair (7,8).
- `out_ready` toggling 1,0,1,0 → each pair is held across stall cycles, and no pair is dropped or duplicated.
- Assert `rst` after 5 samples of frame 2 → the next cycle has `out_valid` = 0 and `in_ready` = 0. After release, a fresh frame 11..18 yields (11,12) first.
- With `FFT_DEINT_BITREV_EN`, feed 1..8 → pairs (1,2), (5,6), (3,4), (7,8) with `out_idx` 0, 2, 1, 3.
- Continuous 64-sample stream with `out_ready` = 1 → `in_ready` never deasserts, and the output matches a reference model pair-for-pair.
